// File: rtl/encoder_8_to_3_serial.sv
// encoder_8_to_3_serial
//   Accepts an 8-bit decoded word and emits the index of each set line, one
//   beat per line, highest index first. An all-zero word yields a single beat
//   flagged with out_none.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_lines, in_valid  input word and its valid
//   in_ready            block can take a word this cycle (combinational)
//   out_code            index of the current active line
//   out_valid           beat valid (registered)
//   out_ready           sink takes the current beat
//   out_last            final beat of the word
//   out_none            word was all-zero, beat carries no line
//   word_count          words accepted since reset, mod 256 (registered)
module encoder_8_to_3_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_lines,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_none,
  output logic [7:0] word_count
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt;
  logic       none_q, none_nxt;
  logic       accept, consume;
  logic       at_most_one;

  // Priority encoder: the loop runs upward so the highest set bit wins.
  always_comb begin
    out_code = 3'd0;
    for (int i = 0; i < 8; i++)
      if (pending[i]) out_code = 3'(i);
  end

  // x & (x-1) clears the lowest set bit; zero result means <=1 bit set.
  assign at_most_one = (pending & (pending - 8'd1)) == 8'd0;

  assign out_last = (state == DRAIN) && at_most_one;
  assign out_none = (state == DRAIN) && none_q;
  // Ready during the final beat too, so back-to-back words have no bubble.
  assign in_ready = (state == IDLE) || ((state == DRAIN) && out_last && out_ready);

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    none_nxt    = none_q;
    if (accept) begin
      // Covers both IDLE load and the final-beat-plus-new-word overlap.
      state_nxt   = DRAIN;
      pending_nxt = in_lines;
      none_nxt    = (in_lines == 8'd0);
    end else if (consume) begin
      if (out_last) begin
        state_nxt   = IDLE;
        pending_nxt = 8'd0;
        none_nxt    = 1'b0;
      end else begin
        pending_nxt = pending & ~(8'd1 << out_code);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 8'd0;
      none_q     <= 1'b0;
      out_valid  <= 1'b0;
      word_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      none_q     <= none_nxt;
      // Registered copy of "in DRAIN" so out_valid comes straight off a flop.
      out_valid  <= (state_nxt == DRAIN);
      word_count <= word_count + 8'(accept);
    end
  end

endmodule
